// File: rtl/usb_buffer_ctrl.sv
// Packet buffer between the USB satellite and the USB RX/TX engines: 64-byte FWFT FIFO,
// host/USB arbitration and TX packet sequencing with sticky overflow/underflow status.
//
// state       | meaning
// S_IDLE      | FIFO open to host and RX engine; waiting for a tx_packet command
// S_TX_START  | one-cycle tx_start pulse to the TX engine
// S_TX_ACTIVE | TX engine drains the FIFO with tx_get until tx_done or tx_error
// S_FLUSH     | aborted packet; FIFO emptied, back to IDLE next cycle
module usb_buffer_ctrl #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk_sys,
  input  logic          rst,
  input  logic          store_tx_data,
  input  logic [7:0]    tx_data,
  input  logic          get_rx_data,
  output logic [7:0]    rx_data,
  input  logic          clear,
  input  logic [3:0]    tx_packet,
  output logic          tx_packet_ack,
  output logic          buf_busy,
  output logic [AW:0]   buffer_occupancy,
  input  logic          rx_store,
  input  logic [7:0]    rx_byte,
  output logic          tx_start,
  output logic [3:0]    tx_pid,
  input  logic          tx_get,
  output logic [7:0]    tx_byte,
  input  logic          tx_done,
  input  logic          tx_error,
  output logic          tx_transfer_active,
  output logic          overflow_err,
  output logic          underflow_err
);

  typedef enum logic [1:0] {S_IDLE, S_TX_START, S_TX_ACTIVE, S_FLUSH} state_t;

  state_t      state_q, state_d;
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [3:0]  tx_pid_q, tx_pid_d;
  logic        ovf_q, ovf_d, unf_q, unf_d;
  logic [7:0]  mem_q [DEPTH];

  logic [AW:0] occ;
  logic        full, empty, is_idle, flush;
  logic        push_req, pop_req, do_push, do_pop, mem_we;
  logic [7:0]  push_data;

  always_comb begin
    occ       = wptr_q - rptr_q;
    full      = (occ == (AW+1)'(DEPTH));
    empty     = (occ == '0);
    is_idle   = (state_q == S_IDLE);
    buf_busy  = ~is_idle | rx_store;
    push_req  = (rx_store & is_idle) | (store_tx_data & ~buf_busy);
    push_data = rx_store ? rx_byte : tx_data;
    pop_req   = (get_rx_data & ~buf_busy) | (tx_get & (state_q == S_TX_ACTIVE));
    do_pop    = pop_req & ~empty;
    // a full FIFO still accepts a push when a pop frees a slot in the same cycle
    do_push   = push_req & (~full | do_pop);
    flush     = ((state_q == S_TX_ACTIVE) & tx_error) | (state_q == S_FLUSH);
    mem_we    = do_push & ~clear & ~flush;
  end

  always_comb begin
    state_d       = state_q;
    tx_pid_d      = tx_pid_q;
    tx_packet_ack = 1'b0;
    tx_start      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_packet != 4'd0) begin
          tx_packet_ack = 1'b1;
          if (tx_packet <= 4'd4) begin
            tx_pid_d = tx_packet;
            state_d  = S_TX_START;
          end
        end
      end
      S_TX_START: begin
        tx_start = 1'b1;
        state_d  = S_TX_ACTIVE;
      end
      S_TX_ACTIVE: begin
        if (tx_error)     state_d = S_FLUSH;
        else if (tx_done) state_d = S_IDLE;
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d = rptr_q + {{AW{1'b0}}, do_pop};
    ovf_d  = ovf_q | (push_req & full & ~do_pop);
    unf_d  = unf_q | (pop_req & empty);
    if (clear || flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end
    if (clear) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      tx_pid_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      tx_pid_q <= tx_pid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // storage needs no reset; the head output is masked while empty
  always_ff @(posedge clk_sys) begin
    if (mem_we) mem_q[wptr_q[AW-1:0]] <= push_data;
  end

  assign rx_data            = empty ? 8'h00 : mem_q[rptr_q[AW-1:0]];
  assign tx_byte            = rx_data;
  assign buffer_occupancy   = occ;
  assign tx_pid             = tx_pid_q;
  assign tx_transfer_active = (state_q == S_TX_START) | (state_q == S_TX_ACTIVE);
  assign overflow_err       = ovf_q;
  assign underflow_err      = unf_q;

endmodule
